// File: rtl/sm3_msg_feeder.sv
// SM3 message feeder: packs 32-bit words into 512-bit blocks for the
// hash core, keeps one block in flight and returns the final digest.
module sm3_msg_feeder #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [31:0]  i_word,
  input  logic         i_word_valid,
  input  logic         i_word_last,
  input  logic [1:0]   i_last_bytes,
  output logic         o_word_ready,
  output logic [511:0] o_data,
  output logic         o_input_valid,
  output logic         o_multi_flag,
  output logic [5:0]   o_byte_nums,
  output logic         o_m_l_bflag,
  input  logic [255:0] i_hash_result,
  input  logic         i_output_valid,
  output logic [255:0] o_digest,
  output logic         o_done,
  output logic         o_err,
  output logic         o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, FILL, ISSUE, WAIT, FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [4:0]    cnt;
  logic [511:0]  blk;
  logic [TW-1:0] tmo;
  logic          fin;
  logic          flush;

  logic          accept;
  logic          to_issue;
  logic          tmo_hit;
  logic [31:0]   word_m;
  logic [511:0]  fill;
  logic [6:0]    nbytes;

  assign accept   = i_word_valid & o_word_ready;
  assign to_issue = accept & (i_word_last | (cnt == 5'd15));
  assign tmo_hit  = (tmo == TW'(TIMEOUT_CYCLES - 1));

  // Bytes past the end of the message are forced to zero.
  always_comb begin
    word_m = i_word;
    if (i_word_last) begin
      case (i_last_bytes)
        2'd1:    word_m = {i_word[31:24], 24'h0};
        2'd2:    word_m = {i_word[31:16], 16'h0};
        2'd3:    word_m = {i_word[31:8], 8'h0};
        default: word_m = i_word;
      endcase
    end
  end

  assign fill   = blk | ({word_m, 480'h0} >> {cnt, 5'b0});
  assign nbytes = {cnt, 2'b00}
                + ((i_last_bytes == 2'd0) ? 7'd4 : {5'd0, i_last_bytes});

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = to_issue ? ISSUE : FILL;
      end
      FILL: begin
        if (to_issue) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (i_output_valid)
          state_nxt = fin ? IDLE : (flush ? FLUSH : FILL);
        else if (tmo_hit)
          state_nxt = IDLE;
      end
      FLUSH: state_nxt = ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_word_ready  = 1'b0;
    o_input_valid = 1'b0;
    o_busy        = 1'b0;
    unique case (state)
      IDLE: o_word_ready = !i_rst;
      FILL: begin
        o_word_ready = !i_rst && (cnt < 5'd16);
        o_busy       = 1'b1;
      end
      ISSUE: begin
        o_input_valid = 1'b1;
        o_busy        = 1'b1;
      end
      default: o_busy = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt          <= '0;
      blk          <= '0;
      tmo          <= '0;
      fin          <= 1'b0;
      flush        <= 1'b0;
      o_data       <= '0;
      o_multi_flag <= 1'b0;
      o_m_l_bflag  <= 1'b0;
      o_byte_nums  <= '0;
      o_digest     <= '0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      unique case (state)
        IDLE, FILL: begin
          if (to_issue) begin
            o_data <= fill;
            blk    <= '0;
            cnt    <= '0;
            if (!i_word_last || nbytes[6]) begin
              // full block; a message ending here still needs a pad block
              o_multi_flag <= 1'b1;
              o_m_l_bflag  <= 1'b0;
              o_byte_nums  <= '0;
              fin          <= 1'b0;
              flush        <= i_word_last;
            end else begin
              o_m_l_bflag <= o_multi_flag;
              o_byte_nums <= nbytes[5:0];
              fin         <= 1'b1;
            end
          end else if (accept) begin
            blk <= fill;
            cnt <= cnt + 5'd1;
          end
        end
        ISSUE: tmo <= '0;
        WAIT: begin
          if (i_output_valid) begin
            if (fin) begin
              o_digest     <= i_hash_result;
              o_done       <= 1'b1;
              o_multi_flag <= 1'b0;
              o_m_l_bflag  <= 1'b0;
              o_byte_nums  <= '0;
              fin          <= 1'b0;
            end
          end else if (tmo_hit) begin
            o_err        <= 1'b1;
            o_multi_flag <= 1'b0;
            o_m_l_bflag  <= 1'b0;
            o_byte_nums  <= '0;
            fin          <= 1'b0;
            flush        <= 1'b0;
            cnt          <= '0;
            blk          <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FLUSH: begin
          o_data       <= '0;
          o_multi_flag <= 1'b1;
          o_m_l_bflag  <= 1'b1;
          o_byte_nums  <= '0;
          fin          <= 1'b1;
          flush        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_msg_feeder.sv
// Directed bench for sm3_msg_feeder: scoreboard of expected blocks and
// digests, a delayed hash-core responder and immediate assertions.
module tb_sm3_msg_feeder;

  localparam int TO = 2048;
  localparam logic [255:0] ABC =
    256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;

  typedef struct packed {
    logic [511:0] data;
    logic         multi;
    logic         ml;
    logic [5:0]   bn;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [31:0]  i_word;
  logic         i_word_valid;
  logic         i_word_last;
  logic [1:0]   i_last_bytes;
  logic         o_word_ready;
  logic [511:0] o_data;
  logic         o_input_valid;
  logic         o_multi_flag;
  logic [5:0]   o_byte_nums;
  logic         o_m_l_bflag;
  logic [255:0] i_hash_result;
  logic         i_output_valid;
  logic [255:0] o_digest;
  logic         o_done;
  logic         o_err;
  logic         o_busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int strobe_cyc = 0;
  int err_cyc = 0;
  int pend = 0;
  logic pend_fin = 1'b0;
  logic rsp_en = 1'b1;
  int rsp_dly = 3;
  logic [255:0] rsp_hash = '0;

  exp_t         blk_q[$];
  logic [255:0] dig_q[$];
  int           ov_hist[$];
  logic [31:0]  msg_w[64];
  int           acc_at[64];

  always #5 clk = ~clk;

  sm3_msg_feeder #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_word        (i_word),
    .i_word_valid  (i_word_valid),
    .i_word_last   (i_word_last),
    .i_last_bytes  (i_last_bytes),
    .o_word_ready  (o_word_ready),
    .o_data        (o_data),
    .o_input_valid (o_input_valid),
    .o_multi_flag  (o_multi_flag),
    .o_byte_nums   (o_byte_nums),
    .o_m_l_bflag   (o_m_l_bflag),
    .i_hash_result (i_hash_result),
    .i_output_valid(i_output_valid),
    .o_digest      (o_digest),
    .o_done        (o_done),
    .o_err         (o_err),
    .o_busy        (o_busy)
  );

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int j);
    logic [31:0] w;
    w = msg_w[j / 4];
    return w[31 - 8 * (j % 4) -: 8];
  endfunction

  function automatic logic [511:0] blk_of(input int start, input int n);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < n; i++) d[511 - 8 * i -: 8] = msg_byte(start + i);
    return d;
  endfunction

  task automatic push_blk(input logic [511:0] d, input logic m,
                          input logic l, input int bn);
    exp_t e;
    e.data  = d;
    e.multi = m;
    e.ml    = l;
    e.bn    = 6'(bn);
    blk_q.push_back(e);
  endtask

  // Expected blocks from the message length alone.
  task automatic model(input int nw, input logic [1:0] lb);
    int len, k, r;
    len = (nw - 1) * 4 + ((lb == 2'd0) ? 4 : int'(lb));
    if (len <= 63) begin
      push_blk(blk_of(0, len), 1'b0, 1'b0, len);
    end else begin
      k = len / 64;
      r = len - 64 * k;
      for (int b = 0; b < k; b++) push_blk(blk_of(b * 64, 64), 1'b1, 1'b0, 0);
      push_blk(blk_of(k * 64, r), 1'b1, 1'b1, r);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (o_input_valid) begin
      strobe_cyc = cyc;
      chk("strobe_expected", blk_q.size() != 0, 1);
      if (blk_q.size() != 0) begin
        e = blk_q.pop_front();
        chk("blk_data", o_data, e.data);
        chk("blk_multi", o_multi_flag, e.multi);
        chk("blk_ml", o_m_l_bflag, e.ml);
        chk("blk_bytes", o_byte_nums, e.bn);
      end
    end
    if (o_done) begin
      n_done++;
      chk("done_expected", dig_q.size() != 0, 1);
      if (dig_q.size() != 0) chk("digest", o_digest, dig_q.pop_front());
    end
    if (o_err) begin
      n_err++;
      err_cyc = cyc;
    end
  endtask

  task automatic respond();
    i_output_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_output_valid = 1'b1;
        i_hash_result  = pend_fin ? rsp_hash : ~rsp_hash;
        ov_hist.push_back(cyc);
      end
    end else if (rsp_en && o_input_valid) begin
      pend     = rsp_dly;
      pend_fin = !o_multi_flag || o_m_l_bflag;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    respond();
  endtask

  task automatic send_word(input logic [31:0] w, input logic last,
                           input logic [1:0] lb, output int ac);
    i_word       = w;
    i_word_last  = last;
    i_last_bytes = lb;
    i_word_valid = 1'b1;
    ac = -1;
    for (int k = 0; k < 300; k++) begin
      logic g;
      g = o_word_ready;
      if (g) ac = cyc;
      cycle();
      if (g) break;
    end
    chk("word_accept", ac >= 0, 1);
  endtask

  task automatic send_words(input int nw, input logic [1:0] lb,
                            input logic has_last, input logic [255:0] d0);
    for (int i = 0; i < nw; i++) begin
      send_word(msg_w[i], has_last && (i == nw - 1), lb, acc_at[i]);
      if ((i % 16 == 15) || (has_last && i == nw - 1)) begin
        chk("issue_ready", o_word_ready, 0);
        chk("issue_strobe", o_input_valid, 1);
        chk("issue_busy", o_busy, 1);
      end
      if (i == 16) begin
        chk("digest_mid", o_digest, d0);
        chk("multi_mid", o_multi_flag, 1);
      end
    end
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    d0 = n_done;
    for (int i = 0; i < bound && n_done == d0; i++) cycle();
    chk("done_seen", n_done != d0, 1);
  endtask

  task automatic send_msg(input int nw, input logic [1:0] lb,
                          input logic [255:0] h);
    model(nw, lb);
    dig_q.push_back(h);
    rsp_hash = h;
    ov_hist.delete();
    send_words(nw, lb, 1'b1, o_digest);
    wait_done(300);
  endtask

  initial begin
    logic [255:0] dsave;
    int e0, d0;
    i_rst = 1'b1;
    i_word = '0;
    i_word_valid = 1'b0;
    i_word_last = 1'b0;
    i_last_bytes = '0;
    i_hash_result = '0;
    i_output_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", o_data, 0);
    chk("rst_digest", o_digest, 0);
    chk("rst_ready", o_word_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_flags", {o_input_valid, o_multi_flag, o_m_l_bflag,
                      o_byte_nums, o_done, o_err}, 0);
    i_rst = 1'b0;
    #1;
    chk("ready_after_rst", o_word_ready, 1);

    msg_w[0] = 32'h61626300;
    send_msg(1, 2'd3, ABC);
    chk("done_pulse", o_done, 0);
    chk("abc_idle", o_busy, 0);

    for (int i = 0; i < 25; i++) msg_w[i] = $urandom;
    send_msg(25, 2'd0, {8{32'h1234_5678}});
    chk("ov_seen", ov_hist.size() >= 2, 1);
    if (ov_hist.size() >= 2) chk("resume_cycle", acc_at[16], ov_hist[0] + 1);

    for (int i = 0; i < 16; i++) msg_w[i] = $urandom;
    send_msg(16, 2'd0, {8{32'hcafe_f00d}});

    for (int t = 0; t < 3; t++) begin
      int nw;
      logic [1:0] lb;
      nw = (t == 0) ? 16 : ((t == 1) ? 17 : 32);
      lb = (t == 0) ? 2'd3 : ((t == 1) ? 2'd1 : 2'd0);
      for (int i = 0; i < nw; i++) msg_w[i] = $urandom;
      send_msg(nw, lb, {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom});
    end

    rsp_en = 1'b0;
    dsave = o_digest;
    for (int i = 0; i < 16; i++) msg_w[i] = $urandom;
    push_blk(blk_of(0, 64), 1'b1, 1'b0, 0);
    send_words(16, 2'd0, 1'b0, dsave);
    e0 = n_err;
    for (int i = 0; i < TO + 100 && n_err == e0; i++) cycle();
    chk("err_seen", n_err != e0, 1);
    chk("err_latency", err_cyc - strobe_cyc, TO + 1);
    chk("err_pulse", o_err, 0);
    chk("tmo_busy", o_busy, 0);
    chk("tmo_multi", o_multi_flag, 0);
    chk("tmo_digest", o_digest, dsave);
    chk("tmo_ready", o_word_ready, 1);

    for (int i = 0; i < 16; i++) msg_w[i] = $urandom;
    push_blk(blk_of(0, 64), 1'b1, 1'b0, 0);
    send_words(16, 2'd0, 1'b0, o_digest);
    cycle();
    chk("wait_busy", o_busy, 1);
    chk("wait_multi", o_multi_flag, 1);
    i_rst = 1'b1;
    cycle();
    chk("arst_data", o_data, 0);
    chk("arst_digest", o_digest, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_ready", o_word_ready, 0);
    chk("arst_flags", {o_input_valid, o_multi_flag, o_m_l_bflag,
                       o_byte_nums, o_done, o_err}, 0);
    i_rst = 1'b0;
    i_output_valid = 1'b1;
    i_hash_result = ~ABC;
    d0 = n_done;
    e0 = n_err;
    repeat (6) cycle();
    chk("no_done_after_rst", n_done, d0);
    chk("no_err_after_rst", n_err, e0);
    chk("post_rst_digest", o_digest, 0);
    chk("post_rst_ready", o_word_ready, 1);

    chk("blk_q_empty", blk_q.size(), 0);
    chk("dig_q_empty", dig_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm3_msg_feeder.md
SM3_MSG_FEEDER -- requirements
Module: sm3_msg_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2048, the maximum number of cycles to wait for a hash-core result before aborting.
REQ-002 SHALL use one clock and a synchronous, active-high reset; port i_clk, input, 1, the clock.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_word, input, 32, message word, big-endian (first message byte in [31:24]).
REQ-005 SHALL have port i_word_valid, input, 1, upstream word valid.
REQ-006 SHALL have port i_word_last, input, 1, the current word is the final word of the message.
REQ-007 SHALL have port i_last_bytes, input, 2, valid bytes in the last word (0 means 4); ignored when i_word_last=0.
REQ-008 SHALL have port o_word_ready, output, 1, the word is accepted on a cycle where i_word_valid and o_word_ready are both 1.
REQ-009 SHALL have port o_data, output, 512, block to the hash core; word 0 in [511:480], unused bytes 0.
REQ-010 SHALL have port o_input_valid, output, 1, one-cycle block strobe.
REQ-011 SHALL have port o_multi_flag, output, 1, the message spans more than one block.
REQ-012 SHALL have port o_byte_nums, output, 6, valid bytes in the final block (0..63).
REQ-013 SHALL have port o_m_l_bflag, output, 1, final-block flag of a multi-block message.
REQ-014 SHALL have port i_hash_result, input, 256, digest from the hash core.
REQ-015 SHALL have port i_output_valid, input, 1, hash-core result strobe.
REQ-016 SHALL have ports o_digest (output, 256), o_done (output, 1), o_err (output, 1) and o_busy (output, 1): final digest, one-cycle completion pulse, one-cycle timeout pulse, and message-in-progress flag.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, ISSUE, WAIT and FLUSH.
- IDLE -> FILL on the first accepted word.
- FILL -> ISSUE when the 16th word is accepted or a last word is accepted.
- ISSUE -> WAIT after one cycle.
- WAIT -> FILL, FLUSH or IDLE on i_output_valid.
- FLUSH -> ISSUE on the next cycle.
REQ-018 SHALL hold o_word_ready=1 only in IDLE and FILL while the word count is below 16; it SHALL be 0 in ISSUE, WAIT and FLUSH.
REQ-019 SHALL pack accepted words at block offset count*32 from the MSB, and SHALL clear the block buffer when each new block begins.
REQ-020 SHALL compute the final-block byte count as 4*(words before last) + (i_last_bytes==0 ? 4 : i_last_bytes), using 7-bit arithmetic.
REQ-021 SHALL, in ISSUE, drive o_input_valid high for exactly one cycle with o_data stable; o_data SHALL remain stable until the next ISSUE.
REQ-022 SHALL send a full block that is not the end of the message with o_multi_flag=1, o_m_l_bflag=0 and o_byte_nums=0.
REQ-023 SHALL, for a message whose total length is 63 bytes or fewer, issue a single block with o_multi_flag=0, o_m_l_bflag=0 and o_byte_nums equal to the length.
REQ-024 SHALL, for a multi-block message, issue the final block with o_multi_flag=1 and o_m_l_bflag=1 in the same cycle as o_input_valid, with o_byte_nums equal to the final-block byte count.
REQ-025 SHALL, when the message ends exactly on a 64-byte boundary, issue that block as a non-final multi block.
- It SHALL then pass through FLUSH and issue an all-zero final block with o_byte_nums=0, o_m_l_bflag=1 and o_multi_flag=1.
- This applies to a 64-byte message too.
REQ-026 SHALL keep o_multi_flag asserted from the first multi block strobe until the cycle after the final i_output_valid.
REQ-027 SHALL hold o_m_l_bflag and o_byte_nums stable from the final strobe until the final i_output_valid.
REQ-028 SHALL keep exactly one block in flight; an i_output_valid for a non-final block only advances WAIT -> FILL and SHALL NOT update o_digest.
REQ-029 SHALL, on the final i_output_valid, register i_hash_result into o_digest, pulse o_done for one cycle and return to IDLE.
- o_digest SHALL hold until the next final result.
REQ-030 SHALL ignore i_output_valid outside WAIT.
REQ-031 SHALL use a WAIT timeout counter that clears on WAIT entry.
- On reaching TIMEOUT_CYCLES-1 without i_output_valid, the block SHALL pulse o_err for one cycle, discard the message and return to IDLE.
- o_digest SHALL be unchanged.
- If i_output_valid and timeout expiry coincide, i_output_valid wins.
REQ-032 SHALL drive o_busy=1 in every state except IDLE.

Reset
REQ-033 SHALL, on i_rst, go to IDLE and clear every output to 0, including o_digest, o_data and the counters; o_word_ready becomes 1 in the first cycle after reset deasserts.
REQ-034 SHALL treat reset mid-operation (any state) as an abort: no o_done or o_err pulse is generated, and an i_output_valid arriving after reset is ignored.

Verification
REQ-035 SHALL cover a single word 0x61626300 with last and i_last_bytes=3.
- Expect one strobe with o_data[511:488]=0x616263 and all other bits 0, o_multi_flag=0, o_byte_nums=3, o_m_l_bflag=0.
- Respond with 0x66c7f0f4...8f4ba8e0; expect o_digest to equal it and o_done=1 for 1 cycle.
REQ-036 SHALL cover a 100-byte message (25 words, i_last_bytes=0).
- Expect block 1 with multi=1, m_l=0, byte_nums=0.
- After i_output_valid, expect block 2 with words 16..24 packed, multi=1, m_l=1, byte_nums=36.
REQ-037 SHALL cover a 64-byte message.
- Expect two strobes; the second has o_data=0, byte_nums=0, m_l=1.
REQ-038 SHALL cover backpressure: hold i_word_valid=1 during WAIT.
- Expect o_word_ready=0, no words lost, and acceptance resuming on the cycle after i_output_valid.
REQ-039 SHALL cover timeout: withhold i_output_valid for 2048 cycles.
- Expect o_err pulse, o_busy=0, o_multi_flag=0, o_digest unchanged, and o_word_ready=1.
REQ-040 SHALL cover reset asserted in WAIT of a multi-block message.
- Expect all outputs 0 on the next cycle and no o_done from a later i_output_valid.
